// File: rtl/sprdma.sv
// sprdma - sprite (OAM) DMA controller.
//
// Snoops the CPU bus. A CPU write to DMA_ADDR with page value P makes the
// block take the cpumc bus. It then copies bytes $P00..$PFF, one at a time,
// to OAMDATA_ADDR, and releases the bus. The top level stalls the CPU with
// ready_in & ~active_out while active_out is high.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   ready_in      debugger ready; low while active freezes the transfer
//   cpu_a_in      CPU address bus (snooped)
//   cpu_dout_in   CPU write data (snooped; page value)
//   cpu_r_nw_in   CPU R/!W
//   cpumc_dout_in read data from the memory bus (1-cycle latency)
//   active_out    DMA owns the bus; CPU stalled
//   a_out         DMA bus address
//   d_out         DMA write data
//   r_nw_out      DMA R/!W
module sprdma #(
  parameter logic [15:0] DMA_ADDR     = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_dout_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpumc_dout_in,
  output logic        active_out,
  output logic [15:0] a_out,
  output logic [7:0]  d_out,
  output logic        r_nw_out
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    RD,
    CAP,
    WR
  } state_t;

  state_t     state;
  logic [7:0] pg;
  logic [7:0] cnt;
  logic [7:0] dreg;
  logic       trig_q;
  logic       trig;

  assign trig = (cpu_a_in == DMA_ADDR) && !cpu_r_nw_in && ready_in;

  // dreg only changes when a byte is captured, so it already holds the
  // last written value outside WR and can drive the data bus directly.
  assign d_out = dreg;

  // Bus outputs are loaded on the same edge that enters the state they
  // belong to, so every output is a plain register. While the debugger
  // holds ready_in low everything except trig_q is held, and the current
  // state simply runs again on resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pg         <= 8'h00;
      cnt        <= 8'h00;
      dreg       <= 8'h00;
      trig_q     <= 1'b0;
      active_out <= 1'b0;
      a_out      <= 16'h0000;
      r_nw_out   <= 1'b1;
    end else begin
      trig_q <= trig;
      if (state == IDLE || ready_in) begin
        case (state)
          IDLE: begin
            // Only the first cycle of a held write starts a transfer.
            if (trig && !trig_q) begin
              pg         <= cpu_dout_in;
              cnt        <= 8'h00;
              state      <= ALIGN;
              active_out <= 1'b1;
              a_out      <= 16'h0000;
              r_nw_out   <= 1'b1;
            end
          end
          ALIGN: begin
            state    <= RD;
            a_out    <= {pg, cnt};
            r_nw_out <= 1'b1;
          end
          RD: begin
            state <= CAP;
          end
          CAP: begin
            dreg     <= cpumc_dout_in;
            state    <= WR;
            a_out    <= OAMDATA_ADDR;
            r_nw_out <= 1'b0;
          end
          WR: begin
            if (cnt == 8'hFF) begin
              state      <= IDLE;
              active_out <= 1'b0;
              a_out      <= 16'h0000;
              r_nw_out   <= 1'b1;
            end else begin
              // 8-bit wrap on purpose: the page is never incremented.
              cnt      <= cnt + 8'd1;
              state    <= RD;
              a_out    <= {pg, cnt + 8'd1};
              r_nw_out <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            active_out <= 1'b0;
            a_out      <= 16'h0000;
            r_nw_out   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprdma.sv
// tb_sprdma - self-checking bench for sprdma.
//
// Holds a 64 KiB memory image that answers bus reads with one cycle of
// latency. A transfer-level model tracks how far the copy has progressed
// and the compare process checks every output against it on each falling
// edge. Directed literal checks pin the model for the scenarios of interest.
module tb_sprdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_in = 1'b1;
  logic [15:0] cpu_a_in = 16'h0000;
  logic [7:0]  cpu_dout_in = 8'h00;
  logic        cpu_r_nw_in = 1'b1;
  logic [7:0]  cpumc_dout_in;
  logic        active_out;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        r_nw_out;

  sprdma dut (
    .clk          (clk),
    .rst          (rst),
    .ready_in     (ready_in),
    .cpu_a_in     (cpu_a_in),
    .cpu_dout_in  (cpu_dout_in),
    .cpu_r_nw_in  (cpu_r_nw_in),
    .cpumc_dout_in(cpumc_dout_in),
    .active_out   (active_out),
    .a_out        (a_out),
    .d_out        (d_out),
    .r_nw_out     (r_nw_out)
  );

  always #5 clk = ~clk;

  // Memory image with one cycle of read latency. While the debugger owns
  // the bus the returned data is corrupted, so a byte captured during a
  // freeze would show up as wrong data.
  logic [7:0] ram [0:65535];
  logic [7:0] rdata_q = 8'h00;

  always @(posedge clk) rdata_q <= ram[active_out ? a_out : cpu_a_in];
  assign cpumc_dout_in = ready_in ? rdata_q : ~rdata_q;

  // Transfer model: step 0 is the alignment cycle, then each byte k takes
  // steps 1+3k (read), 2+3k (read held), 3+3k (write to OAM data).
  logic       m_active = 1'b0;
  int         m_s = 0;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_d = 8'h00;
  logic       m_trigq = 1'b0;

  always @(posedge clk) begin : model
    logic       t;
    logic       na;
    int         ns;
    logic [7:0] np;
    logic [7:0] nd;
    t  = (cpu_a_in == 16'h4014) && !cpu_r_nw_in && ready_in;
    na = m_active;
    ns = m_s;
    np = m_page;
    nd = m_d;
    if (rst) begin
      na = 1'b0;
      ns = 0;
      np = 8'h00;
      nd = 8'h00;
      t  = 1'b0;
    end else if (!m_active) begin
      if (t && !m_trigq) begin
        na = 1'b1;
        ns = 0;
        np = cpu_dout_in;
      end
    end else if (ready_in) begin
      if (m_s == 768) begin
        na = 1'b0;
      end else begin
        ns = m_s + 1;
        if ((ns - 1) % 3 == 2) nd = ram[{m_page, 8'((ns - 1) / 3)}];
      end
    end
    m_active <= na;
    m_s      <= ns;
    m_page   <= np;
    m_d      <= nd;
    m_trigq  <= t;
  end

  function automatic logic [15:0] expA(input int s, input logic [7:0] p);
    if (s == 0) return 16'h0000;
    if ((s - 1) % 3 == 2) return 16'h2004;
    return {p, 8'((s - 1) / 3)};
  endfunction

  function automatic logic expRnw(input int s);
    if (s == 0) return 1'b1;
    return ((s - 1) % 3 != 2);
  endfunction

  int          compared = 0;
  int          mismatched = 0;
  bit          chk_en = 1'b0;
  int          act_total = 0;
  int          wr_total = 0;
  int          hit0800 = 0;
  logic [15:0] last_rd = 16'h0000;
  logic [7:0]  wr_log [0:2047];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model plus bookkeeping of bus activity.
  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checkOutput("active_out", 16'(active_out), 16'(m_active));
        if (m_active) begin
          checkOutput("a_out", a_out, expA(m_s, m_page));
          checkOutput("r_nw_out", 16'(r_nw_out), 16'(expRnw(m_s)));
        end
        checkOutput("d_out", 16'(d_out), 16'(m_d));
      end
      if (active_out) begin
        act_total++;
        if (!r_nw_out) begin
          if (wr_total < 2048) wr_log[wr_total] = d_out;
          wr_total++;
        end else if (a_out != 16'h0000) begin
          last_rd = a_out;
          if (a_out == 16'h0800) hit0800++;
        end
      end
    end
  endtask

  // One CPU bus access held for 'hold' cycles, then the bus goes idle.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input logic rnw, input int hold);
    @(posedge clk);
    #1;
    cpu_a_in    = addr;
    cpu_dout_in = data;
    cpu_r_nw_in = rnw;
    repeat (hold) @(posedge clk);
    #1;
    cpu_a_in    = 16'h0000;
    cpu_dout_in = 8'h00;
    cpu_r_nw_in = 1'b1;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (active_out && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (active_out) checkOutput("idle_timeout", 16'(active_out), 16'h0000);
  endtask

  task automatic waitWrites(input int base, input int target, input int budget);
    int n;
    n = 0;
    while ((wr_total - base) < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if ((wr_total - base) < target) checkOutput("wr_timeout", 16'(wr_total - base), 16'(target));
  endtask

  initial begin
    int act0, wr0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;

    fork
      compareLoop();
    join_none

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    checkOutput("reset_active", 16'(active_out), 16'h0000);
    checkOutput("reset_a", a_out, 16'h0000);
    checkOutput("reset_d", 16'(d_out), 16'h0000);
    checkOutput("reset_rnw", 16'(r_nw_out), 16'h0001);

    // Accesses that must not start a transfer.
    act0 = act_total;
    applyStimulus(16'h4014, 8'h03, 1'b1, 2);
    applyStimulus(16'h4016, 8'h03, 1'b0, 1);
    applyStimulus(16'h2004, 8'h03, 1'b0, 1);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("nontrig_active", 16'(act_total - act0), 16'h0000);

    // Basic copy of page $02.
    act0 = act_total;
    wr0  = wr_total;
    applyStimulus(16'h4014, 8'h02, 1'b0, 1);
    waitIdle(2000);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("basic_active_cycles", 16'(act_total - act0), 16'd769);
    checkOutput("basic_wr_count", 16'(wr_total - wr0), 16'd256);
    checkOutput("basic_wr0", 16'(wr_log[wr0]), 16'h00A5);
    checkOutput("basic_wr1", 16'(wr_log[wr0 + 1]), 16'h00A4);
    checkOutput("basic_wr255", 16'(wr_log[wr0 + 255]), 16'h005A);
    checkOutput("basic_last_rd", last_rd, 16'h02FF);

    // Held trigger: one transfer only, then a new page on a fresh write.
    act0 = act_total;
    wr0  = wr_total;
    applyStimulus(16'h4014, 8'h09, 1'b0, 10);
    waitIdle(2000);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("held_wr_count", 16'(wr_total - wr0), 16'd256);
    checkOutput("held_active_cycles", 16'(act_total - act0), 16'd769);
    wr0 = wr_total;
    applyStimulus(16'h4014, 8'h05, 1'b0, 1);
    waitIdle(2000);
    checkOutput("second_wr_count", 16'(wr_total - wr0), 16'd256);
    checkOutput("second_wr0", 16'(wr_log[wr0]), 16'(ram[16'h0500]));
    checkOutput("second_last_rd", last_rd, 16'h05FF);

    // Page boundary at $07FF.
    act0 = act_total;
    applyStimulus(16'h4014, 8'h07, 1'b0, 1);
    waitIdle(2000);
    #1;
    checkOutput("page7_last_rd", last_rd, 16'h07FF);
    checkOutput("page7_no_0800", 16'(hit0800), 16'h0000);
    checkOutput("page7_active_cycles", 16'(act_total - act0), 16'd769);

    // Debugger pause during the capture of byte 100.
    act0 = act_total;
    wr0  = wr_total;
    applyStimulus(16'h4014, 8'h03, 1'b0, 1);
    waitWrites(wr0, 100, 1000);
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ready_in = 1'b1;
    waitIdle(2000);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("pause_active_cycles", 16'(act_total - act0), 16'd774);
    checkOutput("pause_byte100", 16'(wr_log[wr0 + 100]), 16'(ram[16'h0364]));
    checkOutput("pause_wr_count", 16'(wr_total - wr0), 16'd256);

    // Reset during the write of byte 37.
    wr0 = wr_total;
    applyStimulus(16'h4014, 8'h04, 1'b0, 1);
    waitWrites(wr0, 37, 1000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("rst_mid_active", 16'(active_out), 16'h0000);
    checkOutput("rst_mid_rnw", 16'(r_nw_out), 16'h0001);
    checkOutput("rst_mid_a", a_out, 16'h0000);
    rst = 1'b0;
    act0 = act_total;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("rst_mid_wr_count", 16'(wr_total - wr0), 16'd38);
    checkOutput("rst_mid_no_restart", 16'(act_total - act0), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
